// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter.
// master drives the load/count controls; slave is the counter itself.
interface sync_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic             halt;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload, halt,
        input  cnt, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload, halt,
        output cnt, tc, busy, done
    );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable T-style synchronous down counter with terminal-count pulse.
// Define DOWN_CNT_CASCADE_EN to add borrow_in/borrow_out chaining ports.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DOWN_CNT_CASCADE_EN
    input  logic                borrow_in,
    output logic                borrow_out,
`endif
    sync_down_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] tog;
    logic             borrow_w;
    logic             eff_en;
    logic             at_zero;

`ifdef DOWN_CNT_CASCADE_EN
    assign borrow_w   = borrow_in;
    assign borrow_out = (state_q == RUN) & bus.en & borrow_in & at_zero;
`else
    assign borrow_w = 1'b1;
`endif

    assign eff_en  = bus.en & borrow_w;
    assign at_zero = (cnt_q == '0);

    // bit i toggles when every lower bit is already 0
    always_comb begin
        tog    = '0;
        tog[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tog[i] = tog[i-1] & ~cnt_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            cnt_d    = bus.load_val;
            period_d = bus.load_val;
            state_d  = RUN;
        end else if (state_q == RUN) begin
            if (bus.halt) begin
                state_d = IDLE;
            end else if (eff_en) begin
                if (at_zero) begin
                    tc_d = 1'b1;
                    if (bus.auto_reload) begin
                        cnt_d = period_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q ^ tog;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: directed plan plus random traffic.
module tb_sync_down_counter;
    localparam int W = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    exp_t mexp;
    exp_t mact;
    int   checks = 0;
    int   failures = 0;

    // reference model: remaining count, reload period, mode
    int m_cnt = 0;
    int m_per = 0;
    int m_st  = S_IDLE;
    bit m_tc  = 1'b0;

    task automatic step(input bit r, input bit ld, input int lv,
                        input bit e, input bit ar, input bit h);
        exp_t x;
        @(negedge clk);
        rst_n           = r;
        bus.load        = ld;
        bus.load_val    = W'(lv);
        bus.en          = e;
        bus.auto_reload = ar;
        bus.halt        = h;
        m_tc = 1'b0;
        if (!r) begin
            m_cnt = 0;
            m_per = 0;
            m_st  = S_IDLE;
        end else if (ld) begin
            m_cnt = lv;
            m_per = lv;
            m_st  = S_RUN;
        end else if (m_st == S_RUN && h) begin
            m_st = S_IDLE;
        end else if (m_st == S_RUN && e) begin
            if (m_cnt == 0) begin
                m_tc = 1'b1;
                if (ar) m_cnt = m_per;
                else    m_st  = S_DONE;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        x.cnt  = W'(m_cnt);
        x.tc   = m_tc;
        x.busy = (m_st == S_RUN);
        x.done = (m_st == S_DONE);
        q.push_back(x);
    endtask

    task automatic cnt_step(input bit e, input bit ar);
        step(1'b1, 1'b0, 0, e, ar, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mexp = q.pop_front();
            mact = {bus.cnt, bus.tc, bus.busy, bus.done};
            checks++;
            if (mact !== mexp) begin
                failures++;
                $display("FAIL cyc_check t=%0t got cnt=%0d tc=%b busy=%b done=%b want cnt=%0d tc=%b busy=%b done=%b",
                         $time, mact.cnt, mact.tc, mact.busy, mact.done,
                         mexp.cnt, mexp.tc, mexp.busy, mexp.done);
            end
        end
    end

    initial begin
        bus.load        = 1'b0;
        bus.load_val    = '0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;
        bus.halt        = 1'b0;

        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b0);

        // one-shot of 3, then stray enables in DONE
        step(1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cnt_step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cnt_step(i[0], 1'b0);

        // auto-reload of 2
        step(1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cnt_step(1'b1, 1'b1);

        // en alternating
        step(1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cnt_step(~i[0], 1'b0);

        // mid-count reload, halt and reset
        step(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cnt_step(1'b1, 1'b0);
        step(1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cnt_step(1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cnt_step(1'b1, 1'b0);
        step(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cnt_step(1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        cnt_step(1'b1, 1'b0);

        // load of zero in auto-reload, and load colliding with terminal
        step(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cnt_step(1'b1, 1'b1);
        step(1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0);
        cnt_step(1'b1, 1'b1);

        // full-range sweep
        step(1'b1, 1'b1, 15, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) cnt_step(1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 29) == 0);
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
